// File: rtl/fifo_occ_pkg.sv
// Shared types and default parameters for the FIFO occupancy tracker.
package fifo_occ_pkg;

    typedef enum logic {
        OCC_IDLE = 1'b0,
        OCC_OPEN = 1'b1
    } occ_state_t;

    localparam int unsigned OCC_DEPTH_DEF         = 64;
    localparam int unsigned OCC_STEP_BITS_DEF     = 3;
    localparam int unsigned OCC_AEMPTY_THRESH_DEF = 8;

endpackage

// File: rtl/occ_sat_addsub.sv
// Combinational base + add - sub, clamped to [0, DEPTH], with saturation strobes.
module occ_sat_addsub #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned CNT_BITS  = 7,
    parameter int unsigned STEP_BITS = 3
) (
    input  logic [CNT_BITS-1:0]  base,
    input  logic [STEP_BITS-1:0] add,
    input  logic [STEP_BITS-1:0] sub,
    output logic [CNT_BITS-1:0]  result_c,
    output logic                 ovf_c,
    output logic                 unf_c
);
    localparam int unsigned NW = CNT_BITS + 2;

    logic signed [NW-1:0] net;

    always_comb begin
        net      = signed'(NW'(base)) + signed'(NW'(add)) - signed'(NW'(sub));
        result_c = net[CNT_BITS-1:0];
        ovf_c    = 1'b0;
        unf_c    = 1'b0;
        if (net[NW-1]) begin
            result_c = '0;
            unf_c    = 1'b1;
        end else if (net > signed'(NW'(DEPTH))) begin
            result_c = CNT_BITS'(DEPTH);
            ovf_c    = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_occupancy_tracker.sv
// Packet FIFO occupancy tracker with saturation, sticky errors and checkpoint rollback.
// Optional watermark flags enabled by defining FIFO_OCC_WATERMARK_EN.
module fifo_occupancy_tracker
    import fifo_occ_pkg::*;
#(
    parameter int unsigned DEPTH         = OCC_DEPTH_DEF,
    parameter int unsigned STEP_BITS     = OCC_STEP_BITS_DEF,
    parameter int unsigned AFULL_THRESH  = DEPTH - 8,
    parameter int unsigned AEMPTY_THRESH = OCC_AEMPTY_THRESH_DEF
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         clear,
    input  logic [STEP_BITS-1:0]         up_amt,
    input  logic [STEP_BITS-1:0]         down_amt,
    input  logic                         mark,
    input  logic                         commit,
    input  logic                         rollback,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   free_space,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         pkt_open,
    output logic                         overflow_err,
    output logic                         underflow_err
);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    if (AFULL_THRESH > DEPTH || AEMPTY_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_occupancy_tracker: watermark threshold exceeds DEPTH");
    end

    occ_state_t          state_q, state_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [CNT_BITS-1:0] ckpt_q, ckpt_d;
    logic [CNT_BITS-1:0] free_q, free_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                 rb_eff;
    logic [CNT_BITS-1:0]  cnt_base, cnt_res, ckpt_base, ckpt_res;
    logic [STEP_BITS-1:0] cnt_add;
    logic                 cnt_ovf, cnt_unf;
    logic                 ckpt_ovf_unused, ckpt_unf_unused;

    // Rollback restarts from the checkpoint and discards this cycle's writes.
    assign rb_eff    = rollback && (state_q == OCC_OPEN);
    assign cnt_base  = rb_eff ? ckpt_q : count_q;
    assign cnt_add   = rb_eff ? '0 : up_amt;
    assign ckpt_base = mark ? count_q : ckpt_q;

    occ_sat_addsub #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS), .STEP_BITS(STEP_BITS)) u_cnt (
        .base     (cnt_base),
        .add      (cnt_add),
        .sub      (down_amt),
        .result_c (cnt_res),
        .ovf_c    (cnt_ovf),
        .unf_c    (cnt_unf)
    );

    occ_sat_addsub #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS), .STEP_BITS(STEP_BITS)) u_ckpt (
        .base     (ckpt_base),
        .add      ('0),
        .sub      (down_amt),
        .result_c (ckpt_res),
        .ovf_c    (ckpt_ovf_unused),
        .unf_c    (ckpt_unf_unused)
    );

    always_comb begin
        state_d = state_q;
        count_d = cnt_res;
        ckpt_d  = ckpt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clear) begin
            state_d = OCC_IDLE;
            count_d = '0;
            ckpt_d  = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (rb_eff) begin
            state_d = OCC_IDLE;
        end else begin
            ovf_d = ovf_q | cnt_ovf;
            unf_d = unf_q | cnt_unf;
            if (mark) begin
                state_d = OCC_OPEN;
                ckpt_d  = ckpt_res;
            end else if (commit && (state_q == OCC_OPEN)) begin
                state_d = OCC_IDLE;
            end else if (state_q == OCC_OPEN) begin
                ckpt_d = ckpt_res;
            end
        end
        free_d  = CNT_BITS'(DEPTH) - count_d;
        full_d  = (count_d == CNT_BITS'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= OCC_IDLE;
            count_q <= '0;
            ckpt_q  <= '0;
            free_q  <= CNT_BITS'(DEPTH);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ckpt_q  <= ckpt_d;
            free_q  <= free_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef FIFO_OCC_WATERMARK_EN
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;

    always_comb begin
        afull_d  = (count_d >= CNT_BITS'(AFULL_THRESH));
        aempty_d = (count_d <= CNT_BITS'(AEMPTY_THRESH));
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    assign count         = count_q;
    assign free_space    = free_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign pkt_open      = (state_q == OCC_OPEN);
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_occupancy_tracker.sv
// Scoreboard bench for fifo_occupancy_tracker (DEPTH=64, STEP_BITS=3).
module tb_fifo_occupancy_tracker;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned SB    = 3;
    localparam int unsigned CB    = 7;

    logic          clk = 1'b0;
    logic          n_rst, clear, mark, commit, rollback;
    logic [SB-1:0] up_amt, down_amt;
    logic [CB-1:0] count, free_space;
    logic          full, empty, almost_full, almost_empty, pkt_open;
    logic          overflow_err, underflow_err;

    fifo_occupancy_tracker #(.DEPTH(DEPTH), .STEP_BITS(SB), .AFULL_THRESH(56), .AEMPTY_THRESH(8)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .up_amt(up_amt), .down_amt(down_amt),
        .mark(mark), .commit(commit), .rollback(rollback), .count(count),
        .free_space(free_space), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .pkt_open(pkt_open),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt; int free; int full; int empty; int af; int ae; int open; int ovf; int unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int m_cnt = 0, m_ckpt = 0, m_open = 0, m_ovf = 0, m_unf = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model(input int up, input int dn, input bit mk, input bit cm,
                         input bit rb, input bit cl, input bit rst);
        int old;
        int net;
        old = m_cnt;
        if (!rst || cl) begin
            m_cnt = 0; m_ckpt = 0; m_open = 0; m_ovf = 0; m_unf = 0;
        end else if (rb && m_open == 1) begin
            m_cnt  = clamp0(m_ckpt - dn);
            m_open = 0;
        end else begin
            net = old + up - dn;
            if (net > int'(DEPTH)) begin m_cnt = DEPTH; m_ovf = 1; end
            else if (net < 0) begin m_cnt = 0; m_unf = 1; end
            else m_cnt = net;
            if (mk) begin
                m_ckpt = clamp0(old - dn);
                m_open = 1;
            end else if (cm && m_open == 1) begin
                m_open = 0;
            end else if (m_open == 1) begin
                m_ckpt = clamp0(m_ckpt - dn);
            end
        end
    endtask

    task automatic step(input int up, input int dn, input bit mk = 0, input bit cm = 0,
                        input bit rb = 0, input bit cl = 0, input bit rst = 1);
        exp_t e;
        exp_t g;
        n_rst = rst; clear = cl; mark = mk; commit = cm; rollback = rb;
        up_amt = SB'(up); down_amt = SB'(dn);
        model(up, dn, mk, cm, rb, cl, rst);
        e.cnt = m_cnt; e.free = DEPTH - m_cnt;
        e.full = (m_cnt == DEPTH) ? 1 : 0; e.empty = (m_cnt == 0) ? 1 : 0;
`ifdef FIFO_OCC_WATERMARK_EN
        e.af = (m_cnt >= 56) ? 1 : 0; e.ae = (m_cnt <= 8) ? 1 : 0;
`else
        e.af = 0; e.ae = 0;
`endif
        e.open = m_open; e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check("count", int'(count), g.cnt);
        check("free_space", int'(free_space), g.free);
        check("full", int'(full), g.full);
        check("empty", int'(empty), g.empty);
        check("almost_full", int'(almost_full), g.af);
        check("almost_empty", int'(almost_empty), g.ae);
        check("pkt_open", int'(pkt_open), g.open);
        check("overflow_err", int'(overflow_err), g.ovf);
        check("underflow_err", int'(underflow_err), g.unf);
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; mark = 1'b0; commit = 1'b0; rollback = 1'b0;
        up_amt = '0; down_amt = '0;

        // Reset
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_free", int'(free_space), 64);
        check("rst_empty", int'(empty), 1);

        // Overflow: 9 x 7 = 63, 10th saturates
        for (int i = 0; i < 9; i++) step(7, 0);
        check("ovf_cnt63", int'(count), 63);
        check("ovf_noerr", int'(overflow_err), 0);
        step(7, 0);
        check("ovf_cnt64", int'(count), 64);
        check("ovf_full", int'(full), 1);
        check("ovf_err", int'(overflow_err), 1);
        step(0, 3);
        check("ovf_sticky", int'(overflow_err), 1);
        step(0, 0, 0, 0, 0, 1);
        check("ovf_cleared", int'(overflow_err), 0);

        // Rollback keeps reads drained during the packet
        step(5, 0); step(5, 0);
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(5, 2);
        check("rb_cnt19", int'(count), 19);
        step(4, 1, 0, 0, 1);
        check("rb_cnt3", int'(count), 3);
        check("rb_closed", int'(pkt_open), 0);

        // Commit, then a stray rollback in IDLE is ignored
        step(0, 0, 0, 0, 0, 1);
        step(5, 0); step(5, 0);
        step(0, 0, 1);
        step(4, 0); step(4, 0);
        step(0, 0, 0, 1);
        check("cm_cnt18", int'(count), 18);
        step(0, 0, 0, 0, 1);
        check("cm_rb_ignored", int'(count), 18);

        // Simultaneous up/down, then underflow
        step(0, 0, 0, 0, 0, 1);
        step(2, 0);
        step(3, 3);
        check("sim_cnt2", int'(count), 2);
        check("sim_noerr", int'(underflow_err), 0);
        step(0, 5);
        check("unf_cnt0", int'(count), 0);
        check("unf_err", int'(underflow_err), 1);

        // Watermark boundary and reset mid-packet
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(7, 0);
        step(6, 0);
        check("wm_cnt55", int'(count), 55);
        step(1, 0);
`ifdef FIFO_OCC_WATERMARK_EN
        check("wm_afull", int'(almost_full), 1);
`else
        check("wm_afull", int'(almost_full), 0);
`endif
        step(0, 0, 1);
        check("wm_open", int'(pkt_open), 1);
        step(3, 0, 0, 0, 0, 0, 0);
        check("rst_mid_open", int'(pkt_open), 0);
        check("rst_mid_cnt", int'(count), 0);

        // Mark + commit together re-checkpoints and stays open
        step(7, 0); step(0, 0, 1); step(2, 0, 1, 1);
        check("mk_cm_open", int'(pkt_open), 1);
        step(0, 0, 0, 0, 1);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 9) == 0),
                 bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 49) == 0),
                 bit'($urandom_range(0, 99) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
